// File: rtl/pixel_write_fifo.sv
// Show-ahead pixel FIFO between the game datapath and the VGA adapter write port.
// Clips off-screen pixels, truncates RGB to COLOUR_BITS per channel, tracks drops.
module pixel_write_fifo #(
    parameter int DEPTH       = 16,
    parameter int COLOUR_BITS = 3,
    parameter int H_RES       = 160,
    parameter int V_RES       = 120
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 x_draw,
    input  logic [7:0]                 y_draw,
    input  logic [23:0]                outColour,
    input  logic                       writeEn,
    input  logic                       vga_ready,
    input  logic                       stat_clear,
    output logic [7:0]                 vga_x,
    output logic [6:0]                 vga_y,
    output logic [3*COLOUR_BITS-1:0]   vga_colour,
    output logic                       vga_plot,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 3 * COLOUR_BITS;
    localparam int EW = 15 + CW;
    localparam logic [8:0]  H_LIM  = 9'(H_RES);
    localparam logic [8:0]  V_LIM  = 9'(V_RES);
    localparam logic [AW:0] FULL   = (AW + 1)'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_level;
    logic [EW-1:0] r_out;
    logic          r_plot;
    logic          r_overflow;
    logic [15:0]   r_dropCount;

    logic          w_candidate;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW-1:0] w_nextRd;
    logic [CW-1:0] w_colourIn;
    logic [EW-1:0] w_entryIn;
    logic          w_unusedColourBits;

    assign w_candidate = writeEn && ({1'b0, x_draw} < H_LIM) && ({1'b0, y_draw} < V_LIM);
    assign w_pop       = r_plot && vga_ready;
    assign w_push      = w_candidate && ((r_level != FULL) || w_pop);
    assign w_drop      = w_candidate && !w_push;
    assign w_nextRd    = r_rdPtr + AW'(1);

    assign w_colourIn  = {outColour[23 -: COLOUR_BITS],
                          outColour[15 -: COLOUR_BITS],
                          outColour[7  -: COLOUR_BITS]};
    assign w_entryIn   = {x_draw, y_draw[6:0], w_colourIn};
    assign w_unusedColourBits = ^outColour;

    // Storage holds every entry including the one currently presented on the outputs.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wrPtr] <= w_entryIn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_level     <= '0;
            r_out       <= '0;
            r_plot      <= 1'b0;
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= w_nextRd;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            // Next head comes from storage if one is queued behind it, else bypasses the push.
            if (w_pop) begin
                if (r_level > (AW + 1)'(1)) begin
                    r_out  <= r_mem[w_nextRd];
                    r_plot <= 1'b1;
                end else if (w_push) begin
                    r_out  <= w_entryIn;
                    r_plot <= 1'b1;
                end else begin
                    r_plot <= 1'b0;
                end
            end else if (!r_plot && w_push) begin
                r_out  <= w_entryIn;
                r_plot <= 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (stat_clear) begin
                r_overflow <= 1'b0;
            end

            // A drop coinciding with a clear restarts the count at one.
            if (stat_clear) begin
                r_dropCount <= w_drop ? 16'd1 : 16'd0;
            end else if (w_drop && (r_dropCount != 16'hFFFF)) begin
                r_dropCount <= r_dropCount + 16'd1;
            end
        end
    end

    assign vga_x      = r_out[EW-1 -: 8];
    assign vga_y      = r_out[CW +: 7];
    assign vga_colour = r_out[CW-1:0];
    assign vga_plot   = r_plot;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_dropCount;

endmodule

// File: tb/tb_pixel_write_fifo.sv
// Self-checking bench for pixel_write_fifo: a cycle model with a scoreboard queue
// of expected pixels, plus directed checks at the interesting points.
module tb_pixel_write_fifo;

    logic        clk;
    logic        reset;
    logic [7:0]  x_draw;
    logic [7:0]  y_draw;
    logic [23:0] outColour;
    logic        writeEn;
    logic        vga_ready;
    logic        stat_clear;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [8:0]  vga_colour;
    logic        vga_plot;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    int errorCount = 0;
    int checkCount = 0;
    bit monEn = 0;

    logic [23:0] expQueue[$];
    int          mLevel = 0;
    logic        mOverflow = 0;
    logic [15:0] mDrops = 0;

    pixel_write_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .x_draw     (x_draw),
        .y_draw     (y_draw),
        .outColour  (outColour),
        .writeEn    (writeEn),
        .vga_ready  (vga_ready),
        .stat_clear (stat_clear),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [23:0] makeEntry(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c);
        return {x, y[6:0], c[23:21], c[15:13], c[7:5]};
    endfunction

    // Drive one cycle of inputs, then return just after the clock edge.
    task automatic applyStimulus(input logic we, input logic [7:0] x, input logic [7:0] y,
                                 input logic [23:0] c, input logic rdy, input logic clr);
        writeEn    = we;
        x_draw     = x;
        y_draw     = y;
        outColour  = c;
        vga_ready  = rdy;
        stat_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'd0, 8'd0, 24'd0, rdy, 1'b0);
        end
    endtask

    // Model checks DUT state mid-cycle, then advances to what the next edge should produce.
    always @(negedge clk) begin
        if (monEn) begin
            logic pop, cand, acc, drop;
            checkOutput("plot", {31'd0, vga_plot}, {31'd0, mLevel != 0});
            checkOutput("level", {27'd0, level}, mLevel);
            checkOutput("overflow", {31'd0, overflow}, {31'd0, mOverflow});
            checkOutput("dropCount", {16'd0, drop_count}, {16'd0, mDrops});
            if (mLevel != 0 && expQueue.size() != 0) begin
                checkOutput("headPixel", {8'd0, vga_x, vga_y, vga_colour}, {8'd0, expQueue[0]});
            end
            if (reset) begin
                expQueue.delete();
                mLevel    = 0;
                mOverflow = 0;
                mDrops    = 0;
            end else begin
                pop  = (mLevel != 0) && vga_ready;
                cand = writeEn && (x_draw < 8'd160) && (y_draw < 8'd120);
                acc  = cand && ((mLevel < 16) || pop);
                drop = cand && !acc;
                if (pop && expQueue.size() != 0) void'(expQueue.pop_front());
                if (acc) expQueue.push_back(makeEntry(x_draw, y_draw, outColour));
                mLevel = mLevel + int'(acc) - int'(pop);
                if (drop) mOverflow = 1;
                else if (stat_clear) mOverflow = 0;
                if (stat_clear) mDrops = drop ? 16'd1 : 16'd0;
                else if (drop && mDrops != 16'hFFFF) mDrops = mDrops + 16'd1;
            end
        end
    end

    initial begin
        logic [15:0] dropsBefore;
        reset = 1;
        writeEn = 0; x_draw = 0; y_draw = 0; outColour = 0; vga_ready = 0; stat_clear = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetPixel", {8'd0, vga_x, vga_y, vga_colour}, 32'd0);
        checkOutput("resetPlot", {31'd0, vga_plot}, 32'd0);
        monEn = 1;
        reset = 0;

        // Single pixel, presented the cycle after the push and popped immediately.
        applyStimulus(1'b1, 8'd5, 8'd7, 24'hE040FF, 1'b1, 1'b0);
        checkOutput("t1Plot", {31'd0, vga_plot}, 32'd1);
        checkOutput("t1X", {24'd0, vga_x}, 32'd5);
        checkOutput("t1Y", {25'd0, vga_y}, 32'd7);
        checkOutput("t1Colour", {23'd0, vga_colour}, {23'd0, 9'b111_010_111});
        idle(1'b1, 1);
        checkOutput("t1LevelAfter", {27'd0, level}, 32'd0);

        // Fill with the adapter stalled, then overrun by three.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b1, 8'(i * 7), 8'(i * 5), {8'(i * 13), 8'(i * 29), 8'(i * 41)}, 1'b0, 1'b0);
        end
        checkOutput("t2Level", {27'd0, level}, 32'd16);
        checkOutput("t2Overflow", {31'd0, overflow}, 32'd1);
        checkOutput("t2Drops", {16'd0, drop_count}, 32'd3);

        // Full with a same-cycle pop: the push is accepted.
        applyStimulus(1'b1, 8'd100, 8'd100, 24'h123456, 1'b1, 1'b0);
        checkOutput("t3Level", {27'd0, level}, 32'd16);
        checkOutput("t3Drops", {16'd0, drop_count}, 32'd3);
        idle(1'b1, 18);
        checkOutput("t3Drained", {27'd0, level}, 32'd0);
        applyStimulus(1'b0, 8'd0, 8'd0, 24'd0, 1'b1, 1'b1);

        // Clipped coordinates are neither stored nor counted.
        applyStimulus(1'b1, 8'd200, 8'd10, 24'hFFFFFF, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd10, 8'd120, 24'hFFFFFF, 1'b1, 1'b0);
        idle(1'b1, 1);
        checkOutput("t4Plot", {31'd0, vga_plot}, 32'd0);
        checkOutput("t4Drops", {16'd0, drop_count}, 32'd0);

        // Reset in the middle of a drain.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i + 20), 8'(i + 30), 24'hA5A5A5 ^ 24'(i), 1'b0, 1'b0);
        end
        idle(1'b1, 2);
        checkOutput("t5LevelBefore", {27'd0, level}, 32'd8);
        reset = 1;
        idle(1'b1, 1);
        reset = 0;
        checkOutput("t5Plot", {31'd0, vga_plot}, 32'd0);
        checkOutput("t5Level", {27'd0, level}, 32'd0);
        checkOutput("t5Pixel", {8'd0, vga_x, vga_y, vga_colour}, 32'd0);
        idle(1'b1, 4);

        // Mixed random traffic with a stalling adapter.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 180)), 8'($urandom_range(0, 135)),
                          24'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
        end
        idle(1'b1, 20);

        // Ready held high: no drops for any write pattern.
        dropsBefore = drop_count;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 159)), 8'($urandom_range(0, 119)),
                          24'($urandom), 1'b1, 1'b0);
        end
        checkOutput("thruDrops", {16'd0, drop_count}, {16'd0, dropsBefore});
        idle(1'b1, 20);

        // Saturate the drop counter, then clear it.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 8'(i), 24'(i * 1000), 1'b0, 1'b0);
        end
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b1, 8'd1, 8'd1, 24'h00FF00, 1'b0, 1'b0);
        end
        checkOutput("t6Saturated", {16'd0, drop_count}, 32'h0000FFFF);
        checkOutput("t6Level", {27'd0, level}, 32'd16);
        applyStimulus(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b1);
        checkOutput("t6Cleared", {16'd0, drop_count}, 32'd0);
        checkOutput("t6OvfCleared", {31'd0, overflow}, 32'd0);
        applyStimulus(1'b1, 8'd2, 8'd2, 24'd0, 1'b0, 1'b1);
        checkOutput("t6ClearDrop", {16'd0, drop_count}, 32'd1);
        checkOutput("t6ClearOvf", {31'd0, overflow}, 32'd1);
        idle(1'b1, 20);
        checkOutput("endEmpty", {27'd0, level}, 32'd0);

        @(negedge clk);
        monEn = 0;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
